serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
Bit-serial add/subtract engine that sequences one 1-bit full-adder cell over WIDTH-bit operands, one bit per clock, LSB first. Holds operands, carry and partial result in registers. Accepts one operation at a time over a valid/ready input handshake and returns the result over a valid/ready output handshake. Sits between a requesting datapath and the shared 1-bit adder cell, trading area for latency.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  request valid
in_ready  output  1  engine can accept a request
a  input  WIDTH  operand A, two's complement
b  input  WIDTH  operand B, two's complement
sub  input  1  0: A+B, 1: A-B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry out of MSB (for sub: 1 = no borrow)
overflow  output  1  signed overflow

Behaviour:
- One clock domain on clk. Reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE; in_ready=1; out_valid=0; sum=0; cout=0; overflow=0; all internal shift, carry and count registers = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a into a_sh and b^{WIDTH{sub}} into b_sh. Carry register initialised to sub (two's-complement +1). Bit count = 0. Go to RUN.
- RUN:
  - in_ready=0; in_valid, a, b and sub are ignored.
  - Each edge, the full-adder cell takes a_sh[0], b_sh[0] and the carry register.
  - The sum bit shifts into the result register at its MSB (shift right). a_sh and b_sh shift right. The carry register takes the cell's carry out.
  - At the edge where count==WIDTH-2, also capture that edge's cell carry out as c_msb_in, the carry into the MSB.
  - At the edge where count==WIDTH-1: load sum with the full shifted result, cout with the final carry, and overflow with c_msb_in XOR the final carry. Go to DONE.
  - Otherwise count increments.
- DONE:
  - out_valid=1, in_ready=0.
  - sum, cout and overflow are held stable until the handshake completes.
  - On an edge with out_ready=1, go to IDLE; out_valid drops the following cycle.
  - A new request can first be accepted on the edge after returning to IDLE. No back-to-back overlap.
- Latency: the request is accepted on edge E0; out_valid is visible after edge E(WIDTH). Minimum issue interval is WIDTH+2 cycles.
- After the output handshake, sum, cout and overflow keep their last values. Consumers must qualify them with out_valid.
- out_ready while not in DONE has no effect. in_valid held high through RUN/DONE is not a second request.
- Reset asserted mid-RUN or in DONE: immediate return to reset values. The partial result is discarded and no out_valid pulse occurs.
- Width rules: internal count is $clog2(WIDTH) bits. There is no extension of operands. cout and overflow are separate from sum.

Decomposition:
- Shared package (serial_arith_pkg):
  - state encoding typedef (IDLE/RUN/DONE, 2 bits)
  - default WIDTH constant
- One sub-module: the existing 1-bit full-adder cell bit_FA_df, instantiated once, purely combinational.
- All state lives in serial_add_ctrl.

Test Plan:
1. WIDTH=8; a=0x05, b=0x03, sub=0 -> sum=0x08, cout=0, overflow=0. out_valid rises exactly 8 edges after acceptance. in_ready=0 from the edge after acceptance until the return to IDLE.
2. Carry and overflow cases:
   - a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, overflow=0.
   - a=0x7F, b=0x01, sub=0 -> sum=0x80, cout=0, overflow=1.
3. Subtract cases:
   - a=0x05, b=0x03, sub=1 -> sum=0x02, cout=1, overflow=0.
   - a=0x03, b=0x05, sub=1 -> sum=0xFE, cout=0, overflow=0.
   - a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, overflow=1.
4. Backpressure:
   - Hold out_ready=0 for 5 cycles in DONE -> out_valid, sum, cout and overflow stay constant and in_ready stays 0.
   - Toggle in_valid with new operands meanwhile -> ignored.
   - Raise out_ready -> IDLE. The next request is accepted and its result is correct.
5. Reset mid-operation:
   - Drive rst_n low asynchronously (between edges) after 3 RUN cycles -> all outputs return to reset values immediately and out_valid never pulses.
   - After release, a=0x10, b=0x20, sub=0 -> sum=0x30.
6. Randomised checker: 200 random a/b/sub at WIDTH=8 and WIDTH=16 with random out_ready stalls. Compare sum, cout and overflow against a reference model computing a + (b^mask) + sub.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic controllers.
//   state_t   : controller FSM encoding (IDLE/RUN/DONE)
//   DEF_WIDTH : default operand width
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/bit_FA_df.sv
// 1-bit full-adder cell, purely combinational.
//   a, b : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module bit_FA_df (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract engine: one full-adder cell walked across WIDTH
// bits, LSB first, one bit per clock.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : request handshake (a, b, sub)
//   a, b                 : two's complement operands
//   sub                  : 0 = a+b, 1 = a-b
//   out_valid/out_ready  : result handshake
//   sum, cout, overflow  : result, carry out of MSB, signed overflow
module serial_add_ctrl
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);

  state_t           state, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             carry, c_msb_in;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co;

  bit_FA_df u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (cnt == CNT_LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          // subtract = a + ~b + 1; the +1 rides in as the initial carry
          a_sh  <= a;
          b_sh  <= b ^ {WIDTH{sub}};
          carry <= sub;
          cnt   <= '0;
        end
        RUN: begin
          res_sh <= {fa_s, res_sh[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_co;
          // carry into the MSB, needed for the signed overflow flag
          if (cnt == CNT_MSB) c_msb_in <= fa_co;
          if (cnt == CNT_LAST) begin
            sum      <= {fa_s, res_sh[WIDTH-1:1]};
            cout     <= fa_co;
            overflow <= c_msb_in ^ fa_co;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench: drives a WIDTH=8 and a WIDTH=16 instance through
// directed and random add/subtract requests, compares against a signed
// integer reference model.
module tb_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;          // 0: 8-bit DUT, 1: 16-bit DUT
  logic        iv = 1'b0, ordy = 1'b0, sub_d = 1'b0;
  logic [31:0] a_d = '0, b_d = '0;

  logic        ir8, ov8, co8, of8, ir16, ov16, co16, of16;
  logic [7:0]  s8;
  logic [15:0] s16;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv & ~sel), .in_ready(ir8),
    .a(a_d[7:0]), .b(b_d[7:0]), .sub(sub_d),
    .out_valid(ov8), .out_ready(ordy & ~sel),
    .sum(s8), .cout(co8), .overflow(of8)
  );

  serial_add_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv & sel), .in_ready(ir16),
    .a(a_d[15:0]), .b(b_d[15:0]), .sub(sub_d),
    .out_valid(ov16), .out_ready(ordy & sel),
    .sum(s16), .cout(co16), .overflow(of16)
  );

  logic        o_ir, o_ov, o_co, o_of;
  logic [31:0] o_sum;
  assign o_ir  = sel ? ir16 : ir8;
  assign o_ov  = sel ? ov16 : ov8;
  assign o_co  = sel ? co16 : co8;
  assign o_of  = sel ? of16 : of8;
  assign o_sum = sel ? {16'd0, s16} : {24'd0, s8};

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the signed and unsigned values.
  function automatic void model(input int w, input longint a, input longint b,
                                input bit sub, output longint s, output bit c,
                                output bit v);
    longint m, sa, sb, r, u;
    m  = (longint'(1) << w) - 1;
    sa = (a >= (longint'(1) << (w-1))) ? a - (longint'(1) << w) : a;
    sb = (b >= (longint'(1) << (w-1))) ? b - (longint'(1) << w) : b;
    r  = sub ? sa - sb : sa + sb;
    v  = (r > (longint'(1) << (w-1)) - 1) || (r < -(longint'(1) << (w-1)));
    s  = r & m;
    // unsigned carry: for add, a+b > max; for sub, no borrow means a >= b
    u  = a + b;
    c  = sub ? (a >= b) : (u > m);
  endfunction

  task automatic reset_outputs(input string tag);
    check({tag, "_ir"},  o_ir,  1);
    check({tag, "_ov"},  o_ov,  0);
    check({tag, "_sum"}, o_sum, 0);
    check({tag, "_co"},  o_co,  0);
    check({tag, "_of"},  o_of,  0);
  endtask

  // One request/response. Inputs change #1 after posedge.
  task automatic op(input bit w16, input longint a, input longint b, input bit sub,
                    input int stall, input bit noise);
    int w, lat, k;
    longint es, m;
    bit ec, ev;
    w = w16 ? 16 : 8;
    m = (longint'(1) << w) - 1;
    sel = w16;
    a &= m; b &= m;
    model(w, a, b, sub, es, ec, ev);
    k = 0;
    while (!o_ir && k < 50) begin @(posedge clk); #1; k++; end
    if (!o_ir) check("ready_timeout", 0, 1);
    a_d = 32'(a); b_d = 32'(b); sub_d = sub; iv = 1'b1;
    @(posedge clk); #1;                       // acceptance edge E0
    iv = 1'b0;
    lat = 0;
    while (!o_ov && lat < 40) begin
      if (o_ir) check("run_in_ready", o_ir, 0);
      @(posedge clk); #1; lat++;
    end
    check("latency", lat, w);
    check("sum", o_sum, es);
    check("cout", o_co, ec);
    check("ovf", o_of, ev);
    ordy = 1'b0;
    for (int i = 0; i < stall; i++) begin
      if (noise) begin
        iv = 1'($urandom); a_d = $urandom; b_d = $urandom; sub_d = 1'($urandom);
      end
      @(posedge clk); #1;
      check("hold_ov", o_ov, 1);
      check("hold_ir", o_ir, 0);
      check("hold_sum", o_sum, es);
      check("hold_flags", {o_co, o_of}, {ec, ev});
    end
    iv = 1'b0;
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    check("post_ov", o_ov, 0);
    check("post_sum", o_sum, es);
  endtask

  initial begin
    #12;
    sel = 0; #1 reset_outputs("rst8");
    sel = 1; #1 reset_outputs("rst16");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // directed, WIDTH=8
    op(0, 'h05, 'h03, 0, 0, 0);
    op(0, 'hFF, 'h01, 0, 0, 0);
    op(0, 'h7F, 'h01, 0, 1, 0);
    op(0, 'h05, 'h03, 1, 0, 0);
    op(0, 'h03, 'h05, 1, 0, 0);
    op(0, 'h80, 'h01, 1, 0, 0);
    // backpressure with noise on the request side, then a clean follow-up
    op(0, 'h5A, 'h33, 0, 5, 1);
    op(0, 'h12, 'h34, 1, 0, 0);

    // reset in the middle of RUN
    sel = 0;
    a_d = 32'h77; b_d = 32'h11; sub_d = 0; iv = 1;
    @(posedge clk); #1; iv = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 reset_outputs("midrun_rst");
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 4) begin @(negedge clk); rst_n = 1'b1; end
      if (o_ov) check("no_ov_after_rst", o_ov, 0);
    end
    check("rst_idle", o_ir, 1);
    op(0, 'h10, 'h20, 0, 0, 0);

    // directed, WIDTH=16
    op(1, 'h7FFF, 'h0001, 0, 0, 0);
    op(1, 'h8000, 'h0001, 1, 2, 1);

    // random, both widths
    for (int i = 0; i < 200; i++)
      op(0, $urandom, $urandom, 1'($urandom), $urandom_range(0, 3), 1'($urandom));
    for (int i = 0; i < 200; i++)
      op(1, $urandom, $urandom, 1'($urandom), $urandom_range(0, 3), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
